// File: rtl/muldiv_hilo_unit_pkg.sv
// Purpose: shared op/state encodings, divide-by-zero constants and helpers for the HI/LO unit.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package muldiv_hilo_unit_pkg;

    // Instruction op field as presented on the op port
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } stateT;

    // Divide-by-zero leaves LO all ones; HI gets the original dividend
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    // Two's-complement magnitude of a 32-bit value
    function automatic logic [31:0] absVal(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_hilo_unit_div_step.sv
// Purpose: one restoring-division iteration on unsigned magnitudes.
// Latency: combinational.
// Backpressure: none.
module div_step (
    input  logic [31:0] partRem,
    input  logic        dvdBit,
    input  logic [31:0] divisor,
    output logic [31:0] remNext,
    output logic        qBit
);

    logic [32:0] shifted;
    logic [33:0] trial;

    // Shift in the next dividend bit and try subtracting the divisor
    always_comb begin
        shifted = {partRem, dvdBit};
        trial   = {1'b0, shifted} - {2'b00, divisor};
        qBit    = ~trial[33];
        // Either branch fits in 32 bits: the result is always below the divisor
        remNext = qBit ? trial[31:0] : shifted[31:0];
    end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Purpose: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO (MULDIV_DIV0_FAST_EN shortcuts divide by zero).
// Latency: MUL_LATENCY busy cycles for multiply, 33 for divide (1 for divide by zero when fast), done one cycle later.
// Backpressure: none; busy stalls dependents upstream and start/mthi/mtlo arriving while busy are dropped.
module muldiv_hilo_unit
    import muldiv_hilo_unit_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int DIV_ITERS   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    stateT       state;
    logic [4:0]  counter;
    logic [63:0] product;
    logic [31:0] divisor;
    logic [31:0] dvdQuot;   // dividend bits shift out the top, quotient bits shift in the bottom
    logic [31:0] partRem;
    logic [31:0] origRs;
    logic        signA;
    logic        signB;
    logic        divZero;

    logic        isSignedDiv;
    logic [31:0] absRs;
    logic [31:0] absRt;
    logic [63:0] mulA;
    logic [63:0] mulB;
    logic [31:0] quotSigned;
    logic [31:0] remSigned;
    logic [31:0] remNext;
    logic        qBit;
    logic        fastZero;

`ifdef MULDIV_DIV0_FAST_EN
    assign fastZero = (rt_data == 32'd0);
`else
    assign fastZero = 1'b0;
`endif

    div_step divStepInst (
        .partRem (partRem),
        .dvdBit  (dvdQuot[31]),
        .divisor (divisor),
        .remNext (remNext),
        .qBit    (qBit)
    );

    // Operand conditioning at launch and sign restoration at the end of a divide
    always_comb begin
        isSignedDiv = (op == OP_DIV);
        absRs       = isSignedDiv ? absVal(rs_data) : rs_data;
        absRt       = isSignedDiv ? absVal(rt_data) : rt_data;
        // Sign-extending for MULT makes the low 64 bits of an unsigned multiply correct
        mulA        = (op == OP_MULT) ? {{32{rs_data[31]}}, rs_data} : {32'd0, rs_data};
        mulB        = (op == OP_MULT) ? {{32{rt_data[31]}}, rt_data} : {32'd0, rt_data};
        quotSigned  = (signA ^ signB) ? (~dvdQuot + 32'd1) : dvdQuot;
        remSigned   = signA ? (~partRem + 32'd1) : partRem;
    end

    // Controller FSM with registered busy/done/HI/LO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            counter <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            product <= '0;
            divisor <= '0;
            dvdQuot <= '0;
            partRem <= '0;
            origRs  <= '0;
            signA   <= 1'b0;
            signB   <= 1'b0;
            divZero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state   <= IDLE;
                busy    <= 1'b0;
                counter <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            busy <= 1'b1;
                            if (!op[1]) begin
                                product <= mulA * mulB;
                                counter <= 5'(MUL_LATENCY - 1);
                                state   <= MUL;
                            end else begin
                                signA   <= isSignedDiv & rs_data[31];
                                signB   <= isSignedDiv & rt_data[31];
                                dvdQuot <= absRs;
                                divisor <= absRt;
                                partRem <= '0;
                                origRs  <= rs_data;
                                divZero <= (rt_data == 32'd0);
                                counter <= '0;
                                state   <= fastZero ? FIX : DIV;
                            end
                        end else begin
                            if (mthi) hi <= rs_data;
                            if (mtlo) lo <= rs_data;
                        end
                    end
                    MUL: begin
                        if (counter == 5'd0) begin
                            hi    <= product[63:32];
                            lo    <= product[31:0];
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            counter <= counter - 5'd1;
                        end
                    end
                    DIV: begin
                        partRem <= remNext;
                        dvdQuot <= {dvdQuot[30:0], qBit};
                        if (counter == 5'(DIV_ITERS - 1)) begin
                            counter <= '0;
                            state   <= FIX;
                        end else begin
                            counter <= counter + 5'd1;
                        end
                    end
                    FIX: begin
                        if (divZero) begin
                            hi <= origRs;
                            lo <= DIV0_LO;
                        end else begin
                            hi <= remSigned;
                            lo <= quotSigned;
                        end
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
